db_arbiter: RTL and testbench

Two-master arbiter for the shared memory data bus. It lets the CPU core (master 0) and a second bus master (master 1, e.g. a DMA or display fetcher) share one memory slave. Arbitration is round-robin with a bounded burst length, so a CPU that fetches every cycle cannot starve master 1. It sits between the masters' `db_*` ports and the memory's `db_*` ports, and no protocol changes are required on either side.

---
 rtl/db_arbiter_pkg.sv | 20 ++
 rtl/db_arbiter_if.sv | 27 ++
 rtl/db_arbiter.sv | 133 +++++++++++++
 tb/tb_db_arbiter.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/db_arbiter_pkg.sv
// Shared data-bus definitions for the two-master arbiter.
// Access-type codes and arbiter state encodings.
package db_arbiter_pkg;

  localparam logic [1:0] MEM_ACCESS_NONE = 2'b00;
  localparam logic [1:0] MEM_ACCESS_R    = 2'b01;
  localparam logic [1:0] MEM_ACCESS_W    = 2'b10;
  localparam logic [1:0] MEM_ACCESS_X    = 2'b11;

  typedef enum logic [1:0] {
    DB_ARB_IDLE = 2'd0,
    DB_ARB_OWN0 = 2'd1,
    DB_ARB_OWN1 = 2'd2
  } db_arb_state_t;

  function automatic logic is_req(input logic [1:0] t);
    return t != MEM_ACCESS_NONE;
  endfunction

endpackage

// File: rtl/db_arbiter_if.sv
// Data-bus link between one master and one slave.
// The master drives the request, the slave answers ready/data.
interface db_arbiter_if;

  logic [31:0] addr;
  logic [31:0] data_out;
  logic [1:0]  access_type;
  logic        ready;
  logic [31:0] data_in;

  modport master (
    output addr,
    output data_out,
    output access_type,
    input  ready,
    input  data_in
  );

  modport slave (
    input  addr,
    input  data_out,
    input  access_type,
    output ready,
    output data_in
  );

endinterface

// File: rtl/db_arbiter.sv
// Round-robin two-master arbiter for the shared memory data bus.
// Bursts are bounded only while the other master is waiting.
module db_arbiter
  import db_arbiter_pkg::*;
#(
  parameter int unsigned MAX_BURST = 4
) (
  input  logic         clk,
  input  logic         res,
  db_arbiter_if.slave  m0,
  db_arbiter_if.slave  m1,
  db_arbiter_if.master s,
  output logic [1:0]   grant
);

  localparam logic [7:0] BURST_LAST = 8'(MAX_BURST - 1);

  db_arb_state_t state;
  db_arb_state_t state_n;
  logic          rr;
  logic          rr_n;
  logic [7:0]    beats;
  logic [7:0]    beats_n;

  logic req0;
  logic req1;
  logic accept;
  logic last;

  assign req0   = is_req(m0.access_type);
  assign req1   = is_req(m1.access_type);
  assign accept = is_req(s.access_type) & s.ready;
  assign last   = beats == BURST_LAST;

  // State, round-robin pointer and beat counter registers
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state <= DB_ARB_IDLE;
      rr    <= 1'b0;
      beats <= 8'd0;
    end else begin
      state <= state_n;
      rr    <= rr_n;
      beats <= beats_n;
    end
  end

  // Forward the owner's request; read data goes to both masters
  always_comb begin
    s.addr        = 32'd0;
    s.data_out    = 32'd0;
    s.access_type = MEM_ACCESS_NONE;
    m0.ready      = 1'b0;
    m1.ready      = 1'b0;
    m0.data_in    = s.data_in;
    m1.data_in    = s.data_in;
    grant         = 2'b00;
    unique case (state)
      DB_ARB_OWN0: begin
        s.addr        = m0.addr;
        s.data_out    = m0.data_out;
        s.access_type = m0.access_type;
        m0.ready      = s.ready & req0;
        grant         = 2'b01;
      end
      DB_ARB_OWN1: begin
        s.addr        = m1.addr;
        s.data_out    = m1.data_out;
        s.access_type = m1.access_type;
        m1.ready      = s.ready & req1;
        grant         = 2'b10;
      end
      default: ;
    endcase
  end

  // Grant selection: owner drop first, then burst limit
  always_comb begin
    state_n = state;
    rr_n    = rr;
    beats_n = beats;
    unique case (state)
      DB_ARB_IDLE: begin
        beats_n = 8'd0;
        if (req0 && req1)
          state_n = rr ? DB_ARB_OWN1 : DB_ARB_OWN0;
        else if (req0)
          state_n = DB_ARB_OWN0;
        else if (req1)
          state_n = DB_ARB_OWN1;
      end
      DB_ARB_OWN0: begin
        if (!req0) begin
          state_n = req1 ? DB_ARB_OWN1 : DB_ARB_IDLE;
          rr_n    = 1'b1;
          beats_n = 8'd0;
        end else if (accept) begin
          if (last) begin
            beats_n = 8'd0;
            if (req1) begin
              state_n = DB_ARB_OWN1;
              rr_n    = 1'b1;
            end
          end else begin
            beats_n = beats + 8'd1;
          end
        end
      end
      DB_ARB_OWN1: begin
        if (!req1) begin
          state_n = req0 ? DB_ARB_OWN0 : DB_ARB_IDLE;
          rr_n    = 1'b0;
          beats_n = 8'd0;
        end else if (accept) begin
          if (last) begin
            beats_n = 8'd0;
            if (req0) begin
              state_n = DB_ARB_OWN0;
              rr_n    = 1'b0;
            end
          end else begin
            beats_n = beats + 8'd1;
          end
        end
      end
      default: begin
        state_n = DB_ARB_IDLE;
        beats_n = 8'd0;
      end
    endcase
  end

endmodule

// File: tb/tb_db_arbiter.sv
// Directed per-cycle vector bench for db_arbiter.
// Table rows plus a hand-written reset-mid-stall sequence.
module tb_db_arbiter;
  import db_arbiter_pkg::*;

  localparam logic [1:0] N = MEM_ACCESS_NONE;
  localparam logic [1:0] R = MEM_ACCESS_R;
  localparam logic [1:0] W = MEM_ACCESS_W;
  localparam logic [1:0] X = MEM_ACCESS_X;
  localparam logic [31:0] D0 = 32'h0000_C0DE;

  typedef struct {
    logic        res;
    logic [1:0]  t0;
    logic [31:0] a0;
    logic [1:0]  t1;
    logic [31:0] a1;
    logic [31:0] d1;
    logic        rdy;
    logic [31:0] sdin;
    logic [1:0]  g;
    logic [1:0]  st;
    logic [31:0] sa;
    logic [31:0] sd;
    logic        r0;
    logic        r1;
  } vec_t;

  logic       clk;
  logic       res;
  logic [1:0] grant;
  int         n_chk;
  int         n_fail;

  db_arbiter_if m0_bus();
  db_arbiter_if m1_bus();
  db_arbiter_if s_bus();

  db_arbiter #(.MAX_BURST(4)) dut (
    .clk   (clk),
    .res   (res),
    .m0    (m0_bus),
    .m1    (m1_bus),
    .s     (s_bus),
    .grant (grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(
    input logic res_i,
    input logic [1:0] t0, input logic [31:0] a0,
    input logic [1:0] t1, input logic [31:0] a1,
    input logic [31:0] d1,
    input logic rdy, input logic [31:0] sdin,
    input logic [1:0] g, input logic [1:0] st,
    input logic [31:0] sa, input logic [31:0] sd,
    input logic r0, input logic r1);
    vec_t v;
    v.res = res_i; v.t0 = t0; v.a0 = a0;
    v.t1 = t1; v.a1 = a1; v.d1 = d1;
    v.rdy = rdy; v.sdin = sdin;
    v.g = g; v.st = st; v.sa = sa; v.sd = sd;
    v.r0 = r0; v.r1 = r1;
    return v;
  endfunction

  task automatic chk(input string name, input int row,
                     input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s row %0d: got %h expected %h",
               name, row, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    res                   = v.res;
    m0_bus.access_type    = v.t0;
    m0_bus.addr           = v.a0;
    m0_bus.data_out       = D0;
    m1_bus.access_type    = v.t1;
    m1_bus.addr           = v.a1;
    m1_bus.data_out       = v.d1;
    s_bus.ready           = v.rdy;
    s_bus.data_in         = v.sdin;
  endtask

  task automatic check(input int row, input vec_t v);
    chk("grant", row, {30'd0, grant}, {30'd0, v.g});
    chk("s_type", row, {30'd0, s_bus.access_type}, {30'd0, v.st});
    chk("s_addr", row, s_bus.addr, v.sa);
    chk("s_dout", row, s_bus.data_out, v.sd);
    chk("m0_ready", row, {31'd0, m0_bus.ready}, {31'd0, v.r0});
    chk("m1_ready", row, {31'd0, m1_bus.ready}, {31'd0, v.r1});
    chk("m0_din", row, m0_bus.data_in, v.sdin);
    chk("m1_din", row, m1_bus.data_in, v.sdin);
  endtask

  vec_t tv[$];
  vec_t h;

  initial begin
    n_chk  = 0;
    n_fail = 0;
    // reset with both requesting
    tv.push_back(mk(1,R,'h10,R,'h20,0,1,'h11, 0,N,0,0,0,0));
    tv.push_back(mk(1,R,'h10,R,'h20,0,1,'h12, 0,N,0,0,0,0));
    // burst bound: 4 m0 fetches, then m1 read, then m1 drops
    tv.push_back(mk(0,X,0,R,'h44,'h77,1,'h13, 0,N,0,0,0,0));
    tv.push_back(mk(0,X,0,R,'h44,'h77,1,'h14, 1,X,0,D0,1,0));
    tv.push_back(mk(0,X,4,R,'h44,'h77,1,'h15, 1,X,4,D0,1,0));
    tv.push_back(mk(0,X,8,R,'h44,'h77,1,'h16, 1,X,8,D0,1,0));
    tv.push_back(mk(0,X,12,R,'h44,'h77,1,'h17, 1,X,12,D0,1,0));
    tv.push_back(mk(0,X,16,R,'h44,'h77,1,'h18, 2,R,'h44,'h77,0,1));
    tv.push_back(mk(0,X,16,N,'h44,'h77,1,5, 2,N,'h44,'h77,0,0));
    tv.push_back(mk(0,X,16,N,0,0,1,'h19, 1,X,16,D0,1,0));
    // owner drop after 2 beats, m1 waiting
    tv.push_back(mk(0,X,20,N,0,0,1,'h1A, 1,X,20,D0,1,0));
    tv.push_back(mk(0,N,24,W,'h80,'hBEEF,1,'h1B, 1,N,24,D0,0,0));
    // stall holds ownership
    tv.push_back(mk(0,X,24,W,'h80,'hBEEF,0,'h1C, 2,W,'h80,'hBEEF,0,0));
    tv.push_back(mk(0,X,24,W,'h80,'hBEEF,0,'h1D, 2,W,'h80,'hBEEF,0,0));
    tv.push_back(mk(0,X,24,W,'h80,'hBEEF,0,'h1E, 2,W,'h80,'hBEEF,0,0));
    tv.push_back(mk(0,X,24,W,'h80,'hBEEF,1,'h1F, 2,W,'h80,'hBEEF,0,1));
    tv.push_back(mk(0,X,24,N,'h80,'hBEEF,1,'h20, 2,N,'h80,'hBEEF,0,0));
    tv.push_back(mk(0,X,24,N,0,0,1,'h21, 1,X,24,D0,1,0));
    tv.push_back(mk(0,N,28,N,0,0,1,'h22, 1,N,28,D0,0,0));
    // single master m1 write
    tv.push_back(mk(0,N,0,W,'h40,'hDEAD,1,'h23, 0,N,0,0,0,0));
    tv.push_back(mk(0,N,0,W,'h40,'hDEAD,1,'h24, 2,W,'h40,'hDEAD,0,1));
    tv.push_back(mk(0,N,0,N,'h40,'hDEAD,1,'h25, 2,N,'h40,'hDEAD,0,0));
    tv.push_back(mk(0,N,0,N,0,0,1,'h26, 0,N,0,0,0,0));
    // lone m0 keeps the bus past MAX_BURST
    tv.push_back(mk(0,X,'h100,N,0,0,1,'h27, 0,N,0,0,0,0));
    tv.push_back(mk(0,X,'h100,N,0,0,1,'h28, 1,X,'h100,D0,1,0));
    tv.push_back(mk(0,X,'h104,N,0,0,1,'h29, 1,X,'h104,D0,1,0));
    tv.push_back(mk(0,X,'h108,N,0,0,1,'h2A, 1,X,'h108,D0,1,0));
    tv.push_back(mk(0,X,'h10C,N,0,0,1,'h2B, 1,X,'h10C,D0,1,0));
    tv.push_back(mk(0,X,'h110,N,0,0,1,'h2C, 1,X,'h110,D0,1,0));
    tv.push_back(mk(0,X,'h114,N,0,0,1,'h2D, 1,X,'h114,D0,1,0));
    tv.push_back(mk(0,N,'h118,N,0,0,1,'h2E, 1,N,'h118,D0,0,0));

    res = 1'b1;
    drive(tv[0]);
    for (int i = 0; i < tv.size(); i++) begin
      @(negedge clk);
      drive(tv[i]);
      #2;
      check(i, tv[i]);
    end

    // rr now prefers m1: both request, m1 wins, then stalls
    h = mk(0,R,'h200,R,'h100,'h55,0,'h30, 0,N,0,0,0,0);
    @(negedge clk);
    drive(h);
    #2;
    check(100, h);
    @(negedge clk);
    #2;
    h.g = 2; h.st = R; h.sa = 'h100; h.sd = 'h55;
    check(101, h);
    @(negedge clk);
    #2;
    check(102, h);
    // reset mid-stall takes effect without a clock edge
    #1;
    res = 1'b1;
    #1;
    h.res = 1; h.g = 0; h.st = N; h.sa = 0; h.sd = 0;
    check(103, h);
    @(negedge clk);
    #2;
    check(104, h);
    res = 1'b0;
    h.res = 0;
    #1;
    check(105, h);
    // round-robin restarts with m0 preferred
    @(negedge clk);
    #2;
    h.g = 1; h.st = R; h.sa = 'h200; h.sd = D0; h.r0 = 0;
    check(106, h);
    s_bus.ready = 1'b1;
    #1;
    chk("m0_ready_after_rst", 107, {31'd0, m0_bus.ready}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
